// File: rtl/game_timer_ctrl.sv
// Countdown M:SS game timer sequencing start/pause/resume/expiry/restart on the 1 Hz tick.
// Optional macro GAME_TIMER_BLINK_EN: blink toggles during expiry instead of following expired.
module game_timer_ctrl #(
  parameter int START_MIN = 2,
  parameter int START_SEC = 0
) (
  input  logic       clk_1H,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       restart,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state,
  output logic       running,
  output logic       expired,
  output logic       blink
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  localparam logic [3:0] INIT_MIN   = 4'(START_MIN);
  localparam logic [3:0] INIT_TENS  = 4'(START_SEC / 10);
  localparam logic [3:0] INIT_ONES  = 4'(START_SEC % 10);
  localparam logic       START_ZERO = (START_MIN == 0) && (START_SEC == 0);

  state_t     st;
  logic       start_q, pause_q;
  logic       start_e, pause_e;
  logic [3:0] dec_min, dec_tens, dec_ones;
  logic       dec_zero;

  assign start_e = start & ~start_q;
  assign pause_e = pause & ~pause_q;

  // One-second decrement with BCD borrow; only consumed while in RUN.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec_min  = min_ones;
    dec_tens = sec_tens;
    dec_ones = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_ones = sec_ones - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (sec_tens != 4'd0) begin
        dec_tens = sec_tens - 4'd1;
      end else begin
        dec_tens = 4'd5;
        dec_min  = min_ones - 4'd1;
      end
    end
    dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      start_q  <= 1'b0;
      pause_q  <= 1'b0;
      min_ones <= INIT_MIN;
      sec_tens <= INIT_TENS;
      sec_ones <= INIT_ONES;
    end else begin
      start_q <= start;
      pause_q <= pause;
      if (restart) begin
        st       <= IDLE;
        min_ones <= INIT_MIN;
        sec_tens <= INIT_TENS;
        sec_ones <= INIT_ONES;
      end else begin
        case (st)
          IDLE: begin
            if (start_e) st <= START_ZERO ? EXPIRED : RUN;
          end
          RUN: begin
            if (pause_e) begin
              st <= PAUSE;
            end else begin
              min_ones <= dec_min;
              sec_tens <= dec_tens;
              sec_ones <= dec_ones;
              if (dec_zero) st <= EXPIRED;
            end
          end
          PAUSE: begin
            if (start_e) st <= RUN;
          end
          EXPIRED: st <= EXPIRED;
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign state   = st;
  assign running = (st == RUN);
  assign expired = (st == EXPIRED);

`ifdef GAME_TIMER_BLINK_EN
  logic blink_q;
  logic entering_exp;

  assign entering_exp = ((st == IDLE) && start_e && START_ZERO) ||
                        ((st == RUN) && !pause_e && dec_zero);

  // Set on the expiry edge, then flip every tick while expired.
  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) begin
      blink_q <= 1'b0;
    end else if (restart) begin
      blink_q <= 1'b0;
    end else if (st == EXPIRED) begin
      blink_q <= ~blink_q;
    end else begin
      blink_q <= entering_exp;
    end
  end

  assign blink = blink_q;
`else
  assign blink = expired;
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl: directed test-plan scenarios plus randomized
// start/pause/restart traffic compared against a seconds-count reference model.
module tb_game_timer_ctrl;

  logic       clk_1H = 1'b0;
  logic       reset, start, pause, restart;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic [1:0] state;
  logic       running, expired, blink;

  logic       reset2, start2, pause2, restart2;
  logic [3:0] min_ones2, sec_tens2, sec_ones2;
  logic [1:0] state2;
  logic       running2, expired2, blink2;

  int tests = 0;
  int fails = 0;

  // Reference model: remaining time as a plain second count.
  localparam int START_TOTAL = 120;
  int m_st;
  int m_rem;
  bit m_blink, m_sq, m_pq;

  logic [16:0] obs;
  assign obs = {state, min_ones, sec_tens, sec_ones, running, expired, blink};

  always #5 clk_1H = ~clk_1H;

  game_timer_ctrl dut (
    .clk_1H(clk_1H), .reset(reset), .start(start), .pause(pause), .restart(restart),
    .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones), .state(state),
    .running(running), .expired(expired), .blink(blink)
  );

  game_timer_ctrl #(.START_MIN(0), .START_SEC(3)) dut2 (
    .clk_1H(clk_1H), .reset(reset2), .start(start2), .pause(pause2), .restart(restart2),
    .min_ones(min_ones2), .sec_tens(sec_tens2), .sec_ones(sec_ones2), .state(state2),
    .running(running2), .expired(expired2), .blink(blink2)
  );

  task automatic model_reset();
    m_st = 0; m_rem = START_TOTAL; m_blink = 0; m_sq = 0; m_pq = 0;
  endtask

  task automatic model_step();
    bit se, pe;
    se = start & ~m_sq;
    pe = pause & ~m_pq;
    m_sq = start;
    m_pq = pause;
    if (restart) begin
      m_st = 0; m_rem = START_TOTAL; m_blink = 0;
    end else begin
      case (m_st)
        0: if (se) begin
             if (m_rem == 0) begin m_st = 3; m_blink = 1; end
             else m_st = 1;
           end
        1: if (pe) m_st = 2;
           else begin
             m_rem = m_rem - 1;
             if (m_rem == 0) begin m_st = 3; m_blink = 1; end
           end
        2: if (se) m_st = 1;
        default: m_blink = ~m_blink;
      endcase
    end
  endtask

  function automatic logic [16:0] expect_vec();
    logic b;
`ifdef GAME_TIMER_BLINK_EN
    b = m_blink;
`else
    b = (m_st == 3);
`endif
    return {2'(m_st), 4'(m_rem / 60), 4'((m_rem % 60) / 10), 4'(m_rem % 10),
            (m_st == 1), (m_st == 3), b};
  endfunction

  // Advance one tick: model consumes the levels present at the edge, outputs sampled 1 ns later.
  task automatic step();
    model_step();
    @(posedge clk_1H);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; pause = 0; restart = 0;
    reset2 = 1; start2 = 0; pause2 = 0; restart2 = 0;
    model_reset();
    #1;
    tests++;
    if (obs !== 17'b00_0010_0000_0000_0_0_0) begin
      fails++; $display("FAIL reset_state: got %h want %h", obs, 17'b00_0010_0000_0000_0_0_0);
    end
    tests++;
    if ({state2, min_ones2, sec_tens2, sec_ones2, blink2} !== 15'b00_0000_0000_0011_0) begin
      fails++; $display("FAIL reset_state2: got %h want %h",
                        {state2, min_ones2, sec_tens2, sec_ones2, blink2}, 15'b00_0000_0000_0011_0);
    end
    #11;
    reset = 0; reset2 = 0;
    @(posedge clk_1H); #1;
  endtask

  task automatic test_countdown();
    start = 1;
    step();
    tests++;
    if (state !== 2'b01 || running !== 1'b1 || {min_ones, sec_tens, sec_ones} !== 12'h200) begin
      fails++; $display("FAIL run_entry: got st=%b run=%b %h want st=01 run=1 200",
                        state, running, {min_ones, sec_tens, sec_ones});
    end
    start = 0;
    step();
    tests++;
    if ({min_ones, sec_tens, sec_ones} !== 12'h159) begin
      fails++; $display("FAIL first_dec: got %h want 159", {min_ones, sec_tens, sec_ones});
    end
    for (int k = 3; k <= 121; k++) begin
      step();
      tests++;
      if (obs !== expect_vec()) begin
        fails++; $display("FAIL countdown edge %0d: got %h want %h", k, obs, expect_vec());
      end
    end
    tests++;
    if (state !== 2'b11 || expired !== 1'b1 || blink !== 1'b1 ||
        {min_ones, sec_tens, sec_ones} !== 12'h000) begin
      fails++; $display("FAIL expiry_121: got st=%b exp=%b blink=%b %h want 11 1 1 000",
                        state, expired, blink, {min_ones, sec_tens, sec_ones});
    end
    for (int k = 1; k <= 3; k++) begin
      logic want_b;
`ifdef GAME_TIMER_BLINK_EN
      want_b = (k % 2 == 0);
`else
      want_b = 1'b1;
`endif
      if (k == 2) start = 1;
      step();
      tests++;
      if (blink !== want_b || state !== 2'b11 || {min_ones, sec_tens, sec_ones} !== 12'h000) begin
        fails++; $display("FAIL expired_hold %0d: got blink=%b st=%b %h want blink=%b 11 000",
                          k, blink, state, {min_ones, sec_tens, sec_ones}, want_b);
      end
    end
    start = 0;
    restart = 1;
    step();
    tests++;
    if (state !== 2'b00 || blink !== 1'b0 || {min_ones, sec_tens, sec_ones} !== 12'h200) begin
      fails++; $display("FAIL restart: got st=%b blink=%b %h want 00 0 200",
                        state, blink, {min_ones, sec_tens, sec_ones});
    end
    restart = 0;
    step();
  endtask

  task automatic test_pause_resume();
    start = 1;
    step();
    start = 0;
    repeat (30) step();
    tests++;
    if (state !== 2'b01 || {min_ones, sec_tens, sec_ones} !== 12'h130) begin
      fails++; $display("FAIL reach_130: got st=%b %h want 01 130", state, {min_ones, sec_tens, sec_ones});
    end
    pause = 1;
    step();
    pause = 0;
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (state !== 2'b10 || {min_ones, sec_tens, sec_ones} !== 12'h130 || obs !== expect_vec()) begin
        fails++; $display("FAIL pause_hold %0d: got st=%b %h want 10 130", k, state,
                          {min_ones, sec_tens, sec_ones});
      end
      step();
    end
    start = 1;
    step();
    tests++;
    if (state !== 2'b01 || {min_ones, sec_tens, sec_ones} !== 12'h130) begin
      fails++; $display("FAIL resume: got st=%b %h want 01 130", state, {min_ones, sec_tens, sec_ones});
    end
    start = 0;
    step();
    tests++;
    if ({min_ones, sec_tens, sec_ones} !== 12'h129) begin
      fails++; $display("FAIL resume_dec: got %h want 129", {min_ones, sec_tens, sec_ones});
    end
  endtask

  task automatic test_back_to_back();
    start = 1; pause = 1;
    step();
    tests++;
    if (state !== 2'b10 || {min_ones, sec_tens, sec_ones} !== 12'h129) begin
      fails++; $display("FAIL both_edges: got st=%b %h want 10 129", state, {min_ones, sec_tens, sec_ones});
    end
    step();
    tests++;
    if (state !== 2'b10 || obs !== expect_vec()) begin
      fails++; $display("FAIL both_held: got st=%b want 10", state);
    end
    start = 0; pause = 0;
    restart = 1;
    step();
    restart = 0;
    step();
  endtask

  task automatic test_async_reset();
    start = 1;
    step();
    start = 0;
    repeat (75) step();
    tests++;
    if (state !== 2'b01 || {min_ones, sec_tens, sec_ones} !== 12'h045) begin
      fails++; $display("FAIL reach_045: got st=%b %h want 01 045", state, {min_ones, sec_tens, sec_ones});
    end
    reset = 1;
    #2;
    model_reset();
    tests++;
    if (obs !== 17'b00_0010_0000_0000_0_0_0) begin
      fails++; $display("FAIL async_reset: got %h want %h", obs, 17'b00_0010_0000_0000_0_0_0);
    end
    start = 1;
    #2;
    reset = 0;
    step();
    tests++;
    if (state !== 2'b01 || {min_ones, sec_tens, sec_ones} !== 12'h200) begin
      fails++; $display("FAIL start_after_reset: got st=%b %h want 01 200",
                        state, {min_ones, sec_tens, sec_ones});
    end
    start = 0;
    step();
    tests++;
    if (obs !== expect_vec()) begin
      fails++; $display("FAIL post_reset_dec: got %h want %h", obs, expect_vec());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      start   = ($urandom_range(0, 2) == 0);
      pause   = ($urandom_range(0, 7) == 0);
      restart = ($urandom_range(0, 199) == 0);
      step();
      tests++;
      if (obs !== expect_vec()) begin
        fails++; $display("FAIL random cycle %0d: got %h want %h", k, obs, expect_vec());
      end
    end
    start = 0; pause = 0; restart = 0;
  endtask

  task automatic test_short_start();
    start2 = 1;
    @(posedge clk_1H); #1;
    tests++;
    if (state2 !== 2'b01 || {min_ones2, sec_tens2, sec_ones2} !== 12'h003) begin
      fails++; $display("FAIL short_entry: got st=%b %h want 01 003", state2, {min_ones2, sec_tens2, sec_ones2});
    end
    start2 = 0;
    for (int k = 1; k <= 3; k++) begin
      logic [11:0] want_d;
      logic [1:0]  want_s;
      want_d = 12'(3 - k);
      want_s = (k == 3) ? 2'b11 : 2'b01;
      @(posedge clk_1H); #1;
      tests++;
      if (state2 !== want_s || {min_ones2, sec_tens2, sec_ones2} !== want_d) begin
        fails++; $display("FAIL short_count %0d: got st=%b %h want %b %h", k, state2,
                          {min_ones2, sec_tens2, sec_ones2}, want_s, want_d);
      end
    end
    tests++;
    if (expired2 !== 1'b1 || blink2 !== 1'b1) begin
      fails++; $display("FAIL short_flags: got exp=%b blink=%b want 1 1", expired2, blink2);
    end
    start2 = 1;
    @(posedge clk_1H); #1;
    @(posedge clk_1H); #1;
    tests++;
    if (state2 !== 2'b11 || {min_ones2, sec_tens2, sec_ones2} !== 12'h000) begin
      fails++; $display("FAIL short_start_ignored: got st=%b %h want 11 000",
                        state2, {min_ones2, sec_tens2, sec_ones2});
    end
    start2 = 0;
  endtask

  initial begin
    test_reset();
    test_short_start();
    test_countdown();
    test_pause_resume();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
